// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Data-bus slave with a register-array memory and programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    output logic                 ProtoErr
);

    localparam int c_cnt_w = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam int c_depth = 1 << ADDR_BITS;
    localparam logic [c_cnt_w-1:0] c_lat = c_cnt_w'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [c_cnt_w-1:0]   cnt_q;
    logic [c_cnt_w-1:0]   cnt_d;
    logic                 perr_q;
    logic                 perr_d;
    logic [WORD_SIZE-1:0] mem_q [c_depth];

    logic                 w_req;
    logic                 w_conflict;
    logic                 w_wr_done;
    logic [ADDR_BITS-1:0] w_addr;
    logic [1:0]           w_state;

    assign w_req      = ReadData | WriteData;
    assign w_conflict = ReadData & WriteData;
    assign w_addr     = DataAddr[ADDR_BITS-1:0];

    // Upper address bits alias onto the low words by design.
    generate
        if (WORD_SIZE > ADDR_BITS) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^DataAddr[WORD_SIZE-1:ADDR_BITS];
        end
    endgenerate

    // Logical transfer state, derived from the wait counter and live request.
    always_comb begin
        w_state = S_IDLE;
        if (w_req) begin
            if (cnt_q != c_lat) begin
                w_state = S_WAIT;
            end else begin
                w_state = S_DONE;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            perr_q <= perr_d;
        end
    end

    // Counter clears on completion and idle so every transfer pays full latency.
    always_comb begin
        cnt_d  = '0;
        perr_d = perr_q | w_conflict;
        if (w_state == S_WAIT) begin
            cnt_d = cnt_q + c_cnt_w'(1);
        end
    end

    always_comb begin
        DataWaitreq = 1'b0;
        DataIn      = '0;
        w_wr_done   = 1'b0;
        if (!Reset) begin
            DataWaitreq = (w_state == S_WAIT);
            if (w_state == S_DONE) begin
                w_wr_done = WriteData;
                if (!WriteData) begin
                    DataIn = mem_q[w_addr];
                end
            end
        end
    end

    assign ProtoErr = perr_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < c_depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr_done) begin
            mem_q[w_addr] <= DataOut;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed vector bench for data_mem_responder at LATENCY 2 and 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] addr2, wdat2, din2, addr0, wdat0, din0;
    logic        rd2, wr2, wait2, perr2, rd0, wr0, wait0, perr0;

    int total;
    int bad;

    typedef struct {
        int          sel;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_wait;
        logic [15:0] exp_din;
        logic        chk_perr;
        logic        exp_perr;
    } vec_t;

    vec_t tbl[$];

    data_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(2)) u_dut2 (
        .Clock(clk), .Reset(rst), .DataAddr(addr2), .DataOut(wdat2),
        .ReadData(rd2), .WriteData(wr2), .DataIn(din2),
        .DataWaitreq(wait2), .ProtoErr(perr2)
    );

    data_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(0)) u_dut0 (
        .Clock(clk), .Reset(rst), .DataAddr(addr0), .DataOut(wdat0),
        .ReadData(rd0), .WriteData(wr0), .DataIn(din0),
        .DataWaitreq(wait0), .ProtoErr(perr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int sel, input logic rd, input logic wr,
                                input logic [15:0] a, input logic [15:0] wd,
                                input logic ew, input logic [15:0] ed,
                                input logic cp, input logic ep);
        vec_t v;
        v.sel = sel; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
        v.exp_wait = ew; v.exp_din = ed; v.chk_perr = cp; v.exp_perr = ep;
        return v;
    endfunction

    task automatic idle_all();
        rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; wdat2 = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdat0 = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle_all();

        // LATENCY=2 sequence
        tbl.push_back(mk(2, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 0, 1, 16'h0012, 16'hBEEF, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 0, 1, 16'h0012, 16'hBEEF, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 0, 1, 16'h0012, 16'hBEEF, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0012, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0012, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0012, 16'h0000, 0, 16'hBEEF, 1, 0));
        tbl.push_back(mk(2, 0, 0, 16'h0012, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 0, 1, 16'h0007, 16'hAAAA, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 0, 0, 16'h0007, 16'hAAAA, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0007, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0007, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0007, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 0, 1, 16'h0105, 16'h5A5A, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 0, 1, 16'h0105, 16'h5A5A, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 0, 1, 16'h0105, 16'h5A5A, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0005, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0005, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0005, 16'h0000, 0, 16'h5A5A, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0005, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0005, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 0, 16'h0005, 16'h0000, 0, 16'h5A5A, 1, 0));
        tbl.push_back(mk(2, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(2, 1, 1, 16'h0030, 16'h1234, 1, 16'h0000, 0, 0));
        tbl.push_back(mk(2, 1, 1, 16'h0030, 16'h1234, 1, 16'h0000, 1, 1));
        tbl.push_back(mk(2, 1, 1, 16'h0030, 16'h1234, 0, 16'h0000, 1, 1));
        tbl.push_back(mk(2, 1, 0, 16'h0030, 16'h0000, 1, 16'h0000, 1, 1));
        tbl.push_back(mk(2, 1, 0, 16'h0030, 16'h0000, 1, 16'h0000, 1, 1));
        tbl.push_back(mk(2, 1, 0, 16'h0030, 16'h0000, 0, 16'h1234, 1, 1));
        tbl.push_back(mk(2, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1));
        // LATENCY=0 back-to-back
        tbl.push_back(mk(0, 0, 1, 16'h0003, 16'h1111, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 1, 16'h0004, 16'h2222, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0003, 16'h0000, 0, 16'h1111, 1, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0004, 16'h0000, 0, 16'h2222, 1, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0004, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0103, 16'h0000, 0, 16'h1111, 1, 0));

        // Reset pulse mid-cycle with no request
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait2", {15'd0, wait2}, 16'h0000);
        chk("rst_din2", din2, 16'h0000);
        chk("rst_perr2", {15'd0, perr2}, 16'h0000);
        chk("rst_wait0", {15'd0, wait0}, 16'h0000);
        chk("rst_din0", din0, 16'h0000);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_wait2", {15'd0, wait2}, 16'h0000);
        chk("post_rst_din2", din2, 16'h0000);
        chk("post_rst_perr2", {15'd0, perr2}, 16'h0000);
        chk("post_rst_perr0", {15'd0, perr0}, 16'h0000);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            idle_all();
            if (tbl[i].sel == 2) begin
                rd2 = tbl[i].rd; wr2 = tbl[i].wr; addr2 = tbl[i].addr; wdat2 = tbl[i].wdata;
            end else begin
                rd0 = tbl[i].rd; wr0 = tbl[i].wr; addr0 = tbl[i].addr; wdat0 = tbl[i].wdata;
            end
            #1;
            if (tbl[i].sel == 2) begin
                chk($sformatf("v%0d_wait", i), {15'd0, wait2}, {15'd0, tbl[i].exp_wait});
                chk($sformatf("v%0d_din", i), din2, tbl[i].exp_din);
                if (tbl[i].chk_perr)
                    chk($sformatf("v%0d_perr", i), {15'd0, perr2}, {15'd0, tbl[i].exp_perr});
            end else begin
                chk($sformatf("v%0d_wait", i), {15'd0, wait0}, {15'd0, tbl[i].exp_wait});
                chk($sformatf("v%0d_din", i), din0, tbl[i].exp_din);
                if (tbl[i].chk_perr)
                    chk($sformatf("v%0d_perr", i), {15'd0, perr0}, {15'd0, tbl[i].exp_perr});
            end
        end

        // Reset asserted during a WAIT discards the pending write and clears memory
        @(negedge clk);
        idle_all();
        wr2 = 1'b1; addr2 = 16'h0012; wdat2 = 16'hCCCC;
        #1 chk("mw_wait_a", {15'd0, wait2}, 16'h0001);
        @(negedge clk);
        #1 chk("mw_wait_b", {15'd0, wait2}, 16'h0001);
        #1 rst = 1'b1;
        #1;
        chk("mw_rst_wait", {15'd0, wait2}, 16'h0000);
        chk("mw_rst_din", din2, 16'h0000);
        chk("mw_rst_perr", {15'd0, perr2}, 16'h0000);
        wr2 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        rd2 = 1'b1; addr2 = 16'h0012;
        #1;
        chk("mw_rd_wait_a", {15'd0, wait2}, 16'h0001);
        chk("mw_rd_din_a", din2, 16'h0000);
        @(negedge clk);
        #1 chk("mw_rd_wait_b", {15'd0, wait2}, 16'h0001);
        @(negedge clk);
        #1;
        chk("mw_rd_wait_c", {15'd0, wait2}, 16'h0000);
        chk("mw_rd_din_c", din2, 16'h0000);
        @(negedge clk);
        idle_all();
        #1 chk("mw_perr_end", {15'd0, perr2}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
